// File: rtl/regfile_arbiter_pkg.sv
// Shared types and default widths for the register-file arbiter and its helpers.
package regfile_arbiter_pkg;

    localparam int unsigned DefWidth       = 16;
    localparam int unsigned DefRegAddrBits = 16;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    typedef enum logic {
        PortA = 1'b0,
        PortB = 1'b1
    } port_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; the last-grant pointer is owned by the caller.
module rr_arbiter2
    import regfile_arbiter_pkg::*;
(
    input  logic       req_a,
    input  logic       req_b,
    input  port_e      last_grant,
    output logic [1:0] grant
);

    // grant[0] selects port A, grant[1] selects port B
    always_comb begin
        grant = 2'b00;
        unique case ({req_b, req_a})
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == PortB) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one register file between two req/ack clients with round-robin arbitration.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH         = DefWidth,
    parameter int unsigned REG_ADDR_BITS = DefRegAddrBits
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [REG_ADDR_BITS-1:0] a_addr,
    input  logic [WIDTH-1:0]         a_wdata,
    output logic                     a_ack,
    output logic [WIDTH-1:0]         a_rdata,

    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [REG_ADDR_BITS-1:0] b_addr,
    input  logic [WIDTH-1:0]         b_wdata,
    output logic                     b_ack,
    output logic [WIDTH-1:0]         b_rdata,

    output logic                     rf_en,
    output logic                     rf_r_or_w,
    output logic [REG_ADDR_BITS-1:0] rf_addr,
    output logic [WIDTH-1:0]         rf_in,
    input  logic [WIDTH-1:0]         rf_out,

    output logic                     busy,
    output logic                     grant_b
);

    state_e                   state_q, state_d;
    port_e                    last_q;
    port_e                    win_q;
    logic [1:0]               grant;
    logic                     take;

    logic                     sel_we;
    logic [REG_ADDR_BITS-1:0] sel_addr;
    logic [WIDTH-1:0]         sel_wdata;

    logic                     rf_en_q;
    logic                     rf_r_or_w_q;
    logic [REG_ADDR_BITS-1:0] rf_addr_q;
    logic [WIDTH-1:0]         rf_in_q;

    logic                     a_ack_q, b_ack_q;
    logic [WIDTH-1:0]         a_rdata_q, b_rdata_q;

    rr_arbiter2 u_arb (
        .req_a      (a_req),
        .req_b      (b_req),
        .last_grant (last_q),
        .grant      (grant)
    );

    always_comb begin
        sel_we    = grant[1] ? b_we    : a_we;
        sel_addr  = grant[1] ? b_addr  : a_addr;
        sel_wdata = grant[1] ? b_wdata : a_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests are only looked at in IDLE; ACCESS and RESP are fixed single cycles.
    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    state_d = StAccess;
                    take    = 1'b1;
                end
            end
            StAccess: state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // The rf_* flops double as the command registers and are zero outside ACCESS,
    // since the register file writes combinationally while en and write are high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_en_q     <= 1'b0;
            rf_r_or_w_q <= 1'b0;
            rf_addr_q   <= '0;
            rf_in_q     <= '0;
            win_q       <= PortA;
        end else begin
            rf_en_q <= take;
            if (take) begin
                rf_r_or_w_q <= sel_we;
                rf_addr_q   <= sel_addr;
                rf_in_q     <= sel_wdata;
                win_q       <= grant[1] ? PortB : PortA;
            end else begin
                rf_r_or_w_q <= 1'b0;
                rf_addr_q   <= '0;
                rf_in_q     <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
            last_q    <= PortB;
        end else begin
            a_ack_q <= (state_q == StAccess) && (win_q == PortA);
            b_ack_q <= (state_q == StAccess) && (win_q == PortB);
            if (state_q == StAccess) begin
                if (win_q == PortA) begin
                    a_rdata_q <= rf_r_or_w_q ? '0 : rf_out;
                end else begin
                    b_rdata_q <= rf_r_or_w_q ? '0 : rf_out;
                end
            end
            if (state_q == StResp) begin
                last_q <= win_q;
            end
        end
    end

    assign rf_en     = rf_en_q;
    assign rf_r_or_w = rf_r_or_w_q;
    assign rf_addr   = rf_addr_q;
    assign rf_in     = rf_in_q;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign busy      = (state_q != StIdle);
    assign grant_b   = (win_q == PortB);

    a_en_only_in_access: assert property (@(posedge clk) disable iff (rst)
        rf_en_q |-> (state_q == StAccess));
    a_ack_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(a_ack_q && b_ack_q));

endmodule
